// File: rtl/param_mem_ctrl.sv
// Parametrised single-port data memory with a multi-cycle access FSM and a one-cycle ready pulse.
// Optional build macro MEM_PARITY_EN adds a per-word even-parity bit and drives parErr.
module param_mem_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              readMem,
  input  logic              writeMem,
  input  logic [ADDR_W-1:0] addrBus,
  input  logic [DATA_W-1:0] inBus,
  output logic              rdyMem,
  output logic [DATA_W-1:0] outBus,
  output logic              parErr
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  localparam logic       LAT_ONE  = (LATENCY == 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_wr;
  logic [DATA_W-1:0] r_out;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic              w_enter_done;
  logic              w_in_idle;
  logic              w_op_wr;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  assign w_in_idle = (r_state == ST_IDLE);
  assign w_accept  = w_in_idle && (readMem || writeMem);

  // With LATENCY=1 the commit happens on the accept edge itself, so the
  // operands must come straight from the bus rather than the capture regs.
  assign w_op_wr = w_in_idle ? writeMem : r_wr;
  assign w_addr  = w_in_idle ? addrBus  : r_addr;
  assign w_data  = w_in_idle ? inBus    : r_data;

  assign w_enter_done = (w_accept && LAT_ONE) ||
                        ((r_state == ST_BUSY) && (r_cnt == 4'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wr    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= addrBus;
            r_data  <= inBus;
            r_wr    <= writeMem;
            r_cnt   <= CNT_LOAD;
            r_state <= LAT_ONE ? ST_DONE : ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_enter_done && w_op_wr) begin
      r_mem[w_addr] <= w_data;
    end
  end

  // Read data is held until the next read completes; writes leave it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out <= '0;
    end else if (w_enter_done && !w_op_wr) begin
      r_out <= r_mem[w_addr];
    end
  end

  assign rdyMem = (r_state == ST_DONE);
  assign outBus = r_out;

`ifdef MEM_PARITY_EN
  logic r_par [DEPTH];
  logic r_par_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_par[i] <= 1'b0;
      end
    end else if (w_enter_done && w_op_wr) begin
      r_par[w_addr] <= ^w_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par_err <= 1'b0;
    end else if (w_enter_done) begin
      r_par_err <= w_op_wr ? 1'b0 : ((^r_mem[w_addr]) != r_par[w_addr]);
    end
  end

  assign parErr = r_par_err;
`else
  assign parErr = 1'b0;
`endif

endmodule

// File: tb/tb_param_mem_ctrl.sv
// Scoreboard bench for param_mem_ctrl: three instances (LATENCY 2, 1, 4) share clock and reset.
// Parity checks are compiled only when MEM_PARITY_EN is defined.
module tb_param_mem_ctrl;

  localparam int NDUT = 3;

  typedef struct {
    logic [15:0] out;
    logic        par;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd   [NDUT];
  logic        wr   [NDUT];
  logic [7:0]  addr [NDUT];
  logic [15:0] din  [NDUT];
  logic        rdy  [NDUT];
  logic [15:0] dout [NDUT];
  logic        perr [NDUT];

  logic [15:0] model    [NDUT][256];
  logic [15:0] last_out [NDUT];
  logic        last_par [NDUT];
  exp_t        sb [$];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    param_mem_ctrl #(
      .DATA_W (16),
      .ADDR_W (8),
      .LATENCY(gi == 0 ? 2 : (gi == 1 ? 1 : 4))
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .readMem (rd[gi]),
      .writeMem(wr[gi]),
      .addrBus (addr[gi]),
      .inBus   (din[gi]),
      .rdyMem  (rdy[gi]),
      .outBus  (dout[gi]),
      .parErr  (perr[gi])
    );
  end

  function automatic int lat_of(int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < NDUT; d++) begin
      for (int a = 0; a < 256; a++) model[d][a] = 16'h0000;
      last_out[d] = 16'h0000;
      last_par[d] = 1'b0;
    end
  endtask

  // One complete access; toggle=1 wiggles the bus during BUSY to show it is ignored.
  task automatic access(int d, bit w, bit r, logic [7:0] a, logic [15:0] data,
                        bit bad_par, bit toggle, string tag);
    exp_t e;
    int   cyc;
    if (w) begin
      model[d][a] = data;
      last_par[d] = 1'b0;
    end else begin
      last_out[d] = model[d][a];
      last_par[d] = bad_par;
    end
    e.out = last_out[d];
    e.par = last_par[d];
    e.lat = lat_of(d);
    sb.push_back(e);

    @(negedge clk);
    rd[d] = r; wr[d] = w; addr[d] = a; din[d] = data;
    @(posedge clk);
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (rdy[d]) break;
      if (toggle && cyc == 1) begin
        rd[d] = 1'b0; wr[d] = 1'b1; addr[d] = 8'hEE; din[d] = 16'hDEAD;
      end
      if (toggle && cyc == 2) begin
        wr[d] = 1'b0;
      end
    end
    e = sb.pop_front();
    chk({tag, "_lat"}, 32'(cyc), 32'(e.lat));
    chk({tag, "_out"}, 32'(dout[d]), 32'(e.out));
    chk({tag, "_par"}, 32'(perr[d]), 32'(e.par));
    $display("txn %s dut%0d w=%0b r=%0b a=%h d=%h lat=%0d out=%h", tag, d, w, r, a, data, cyc, dout[d]);
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  initial begin
    int seen;
    for (int d = 0; d < NDUT; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = 8'h00; din[d] = 16'h0000;
    end
    model_clear();
    rst = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("rst_rdy", 32'(rdy[d]), 32'd0);
      chk("rst_out", 32'(dout[d]), 32'd0);
      chk("rst_par", 32'(perr[d]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;

    access(0, 0, 1, 8'd1,   16'h0000, 0, 0, "t1_rd1");
    access(0, 1, 0, 8'd3,   16'h000C, 0, 0, "t2_wr3");
    access(0, 0, 1, 8'd3,   16'h0000, 0, 0, "t2_rd3");
    access(0, 1, 0, 8'd10,  16'hFE0F, 0, 0, "t3_wr10");
    access(0, 1, 0, 8'd255, 16'hFFFF, 0, 0, "t3_wr255");
    access(0, 0, 1, 8'd255, 16'h0000, 0, 0, "t3_rd255");
    access(0, 0, 1, 8'd10,  16'h0000, 0, 0, "t3_rd10");
    access(0, 0, 1, 8'd20,  16'h0000, 0, 0, "t3_rd20");
    access(0, 1, 1, 8'd7,   16'hA5A5, 0, 0, "t4_both7");
    access(0, 0, 1, 8'd7,   16'h0000, 0, 0, "t4_rd7");

    // Reset half a cycle after accept must abort the write and clear the array.
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 8'd5; din[0] = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; wr[0] = 1'b0;
    model_clear();
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rdy[0]) seen++;
    end
    chk("t5_rdy_in_rst", 32'(seen), 32'd0);
    chk("t5_out_in_rst", 32'(dout[0]), 32'd0);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rdy[0]) seen++;
    end
    chk("t5_rdy_after", 32'(seen), 32'd0);
    access(0, 0, 1, 8'd5,   16'h0000, 0, 0, "t5_rd5");
    access(0, 0, 1, 8'd255, 16'h0000, 0, 0, "t5_rd255");

    access(1, 1, 0, 8'd0,   16'h5555, 0, 0, "t6_l1_wr0");
    access(1, 0, 1, 8'd0,   16'h0000, 0, 0, "t6_l1_rd0");
    access(1, 1, 0, 8'd255, 16'h8001, 0, 0, "t6_l1_wr255");
    access(1, 0, 1, 8'd255, 16'h0000, 0, 0, "t6_l1_rd255");
    access(2, 1, 0, 8'd3,   16'h3C3C, 0, 0, "t6_l4_wr3");
    access(2, 0, 1, 8'd3,   16'h0000, 0, 1, "t6_l4_rd3_tog");
    access(2, 0, 1, 8'hEE,  16'h0000, 0, 0, "t6_l4_rdEE");

`ifdef MEM_PARITY_EN
    access(0, 1, 0, 8'd3, 16'h000C, 0, 0, "t6_par_wr3");
    g_dut[0].u_dut.r_par[3] = 1'b1;
    access(0, 0, 1, 8'd3, 16'h0000, 1, 0, "t6_par_rd3");
    access(0, 1, 0, 8'd4, 16'h0F00, 0, 0, "t6_par_wr4");
    access(0, 0, 1, 8'd4, 16'h0000, 0, 0, "t6_par_rd4");
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
